rs_age_station: RTL and testbench

Parametrised reservation station for the ALU path of the out-of-order core. It buffers up to DEPTH decoded instructions, wakes their operands from N_CDB broadcast channels, and issues the oldest ready entry through a registered valid/ready port to the ALU. Compared with the fixed 15-slot station, it adds:

- configurable depth and CDB channel count;
- age-ordered selection;
- back-pressure from the ALU;
- occupancy reporting.

It sits between decode/dispatch and the ALU and is flushed by the ROB on misprediction.

---
 rtl/rs_age_station.sv | 233 +++++++++++++++++++++++
 tb/tb_rs_age_station.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rs_age_station.sv
// rs_age_station
// Reservation station for the ALU path. Buffers up to DEPTH dispatched
// instructions, wakes their source operands from N_CDB broadcast channels and
// issues the oldest ready entry through a registered valid/ready port.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   rdy                 global enable; low freezes all state
//   flush               ROB misprediction flush (beats accept/wakeup/issue)
//   in_*                dispatch request and payload (q = 0 means value ready)
//   out_full, out_count occupancy of the entry array (issue register excluded)
//   cdb_valid/tag/data  packed broadcast channels, channel c at [c*W +: W]
//   iss_*               registered issue port, valid/ready handshake
module rs_age_station #(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 32,
  parameter int ROB_W  = 4,
  parameter int OP_W   = 6,
  parameter int N_CDB  = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       rdy,
  input  logic                       flush,
  input  logic                       in_valid,
  input  logic [OP_W-1:0]            in_op,
  input  logic [ROB_W-1:0]           in_rob,
  input  logic [DATA_W-1:0]          in_v1,
  input  logic [DATA_W-1:0]          in_v2,
  input  logic [ROB_W-1:0]           in_q1,
  input  logic [ROB_W-1:0]           in_q2,
  input  logic [DATA_W-1:0]          in_imm,
  input  logic [DATA_W-1:0]          in_pc,
  output logic                       out_full,
  output logic [$clog2(DEPTH+1)-1:0] out_count,
  input  logic [N_CDB-1:0]           cdb_valid,
  input  logic [N_CDB*ROB_W-1:0]     cdb_tag,
  input  logic [N_CDB*DATA_W-1:0]    cdb_data,
  output logic                       iss_valid,
  input  logic                       iss_ready,
  output logic [OP_W-1:0]            iss_op,
  output logic [ROB_W-1:0]           iss_rob,
  output logic [DATA_W-1:0]          iss_v1,
  output logic [DATA_W-1:0]          iss_v2,
  output logic [DATA_W-1:0]          iss_imm,
  output logic [DATA_W-1:0]          iss_pc
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  // Entry storage
  logic [DEPTH-1:0]             valid_q;
  logic [OP_W-1:0]              op_q  [DEPTH];
  logic [ROB_W-1:0]             rob_q [DEPTH];
  logic [DATA_W-1:0]            v1_q  [DEPTH];
  logic [DATA_W-1:0]            v2_q  [DEPTH];
  logic [ROB_W-1:0]             q1_q  [DEPTH];
  logic [ROB_W-1:0]             q2_q  [DEPTH];
  logic [DATA_W-1:0]            imm_q [DEPTH];
  logic [DATA_W-1:0]            pc_q  [DEPTH];
  // age_q[i][j] = 1 : entry i is older than entry j
  logic [DEPTH-1:0][DEPTH-1:0]  age_q;

  // Issue register
  logic                         iss_valid_q;
  logic [OP_W-1:0]              iss_op_q;
  logic [ROB_W-1:0]             iss_rob_q;
  logic [DATA_W-1:0]            iss_v1_q, iss_v2_q, iss_imm_q, iss_pc_q;

  // Post-wakeup operand state for each entry
  logic [DATA_W-1:0]            v1_d [DEPTH];
  logic [DATA_W-1:0]            v2_d [DEPTH];
  logic [ROB_W-1:0]             q1_d [DEPTH];
  logic [ROB_W-1:0]             q2_d [DEPTH];
  logic [DATA_W-1:0]            byp_v1, byp_v2;
  logic [ROB_W-1:0]             byp_q1, byp_q2;

  logic [DEPTH-1:0]             ready;
  logic [DEPTH-1:0]             cand;
  logic [DEPTH-1:0][DEPTH-1:0]  age_col;  // age_col[i][j] = age_q[j][i]
  logic                         sel_found;
  logic [IDX_W-1:0]             sel_idx;
  logic [IDX_W-1:0]             free_idx;
  logic [CNT_W-1:0]             occ;
  logic                         load;
  logic                         accept;

  // Snoop one source tag against all channels. Tag 0 never matches; the loop
  // runs high-to-low so the lowest matching channel is the one that sticks.
  function automatic logic [ROB_W+DATA_W-1:0] snoop(
    input logic [ROB_W-1:0]        tag,
    input logic [DATA_W-1:0]       val,
    input logic [N_CDB-1:0]        cv,
    input logic [N_CDB*ROB_W-1:0]  ct,
    input logic [N_CDB*DATA_W-1:0] cd
  );
    logic [ROB_W+DATA_W-1:0] r;
    r = {tag, val};
    if (tag != '0) begin
      for (int c = N_CDB - 1; c >= 0; c--) begin
        if (cv[c] && (ct[c*ROB_W +: ROB_W] == tag)) begin
          r = {{ROB_W{1'b0}}, cd[c*DATA_W +: DATA_W]};
        end
      end
    end
    return r;
  endfunction

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      {q1_d[i], v1_d[i]} = snoop(q1_q[i], v1_q[i], cdb_valid, cdb_tag, cdb_data);
      {q2_d[i], v2_d[i]} = snoop(q2_q[i], v2_q[i], cdb_valid, cdb_tag, cdb_data);
    end
    {byp_q1, byp_v1} = snoop(in_q1, in_v1, cdb_valid, cdb_tag, cdb_data);
    {byp_q2, byp_v2} = snoop(in_q2, in_v2, cdb_valid, cdb_tag, cdb_data);
  end

  // An entry is a candidate when it is ready and no other ready entry is older.
  genvar gi, gj;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_sel
      assign ready[gi] = valid_q[gi] && (q1_q[gi] == '0) && (q2_q[gi] == '0);
      for (gj = 0; gj < DEPTH; gj++) begin : g_col
        assign age_col[gi][gj] = age_q[gj][gi];
      end
      assign cand[gi] = ready[gi] && ~|(ready & age_col[gi]);
    end
  endgenerate

  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    free_idx  = '0;
    occ       = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (cand[i]) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(i);
      end
      if (!valid_q[i]) begin
        free_idx = IDX_W'(i);
      end
      occ = occ + CNT_W'(valid_q[i]);
    end
  end

  // Free search and fullness use registered valid bits, so a slot vacated by
  // this cycle's issue only becomes reusable next cycle.
  assign out_full  = &valid_q;
  assign out_count = occ;
  assign load      = !iss_valid_q || iss_ready;
  assign accept    = in_valid && !out_full && !flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q     <= '0;
      age_q       <= '0;
      iss_valid_q <= 1'b0;
      iss_op_q    <= '0;
      iss_rob_q   <= '0;
      iss_v1_q    <= '0;
      iss_v2_q    <= '0;
      iss_imm_q   <= '0;
      iss_pc_q    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        op_q[i]  <= '0;
        rob_q[i] <= '0;
        v1_q[i]  <= '0;
        v2_q[i]  <= '0;
        q1_q[i]  <= '0;
        q2_q[i]  <= '0;
        imm_q[i] <= '0;
        pc_q[i]  <= '0;
      end
    end else if (rdy) begin
      if (flush) begin
        valid_q     <= '0;
        iss_valid_q <= 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
          q1_q[i] <= '0;
          q2_q[i] <= '0;
        end
      end else begin
        for (int i = 0; i < DEPTH; i++) begin
          v1_q[i] <= v1_d[i];
          v2_q[i] <= v2_d[i];
          q1_q[i] <= q1_d[i];
          q2_q[i] <= q2_d[i];
        end
        if (load) begin
          iss_valid_q <= sel_found;
          if (sel_found) begin
            iss_op_q          <= op_q[sel_idx];
            iss_rob_q         <= rob_q[sel_idx];
            iss_v1_q          <= v1_q[sel_idx];
            iss_v2_q          <= v2_q[sel_idx];
            iss_imm_q         <= imm_q[sel_idx];
            iss_pc_q          <= pc_q[sel_idx];
            valid_q[sel_idx]  <= 1'b0;
          end
        end
        // The accepted slot is invalid in registered state, so it never
        // collides with the issued slot above.
        if (accept) begin
          valid_q[free_idx] <= 1'b1;
          op_q[free_idx]    <= in_op;
          rob_q[free_idx]   <= in_rob;
          v1_q[free_idx]    <= byp_v1;
          v2_q[free_idx]    <= byp_v2;
          q1_q[free_idx]    <= byp_q1;
          q2_q[free_idx]    <= byp_q2;
          imm_q[free_idx]   <= in_imm;
          pc_q[free_idx]    <= in_pc;
          age_q[free_idx]   <= '0;
          for (int j = 0; j < DEPTH; j++) begin
            if (valid_q[j]) begin
              age_q[j][free_idx] <= 1'b1;
            end
          end
        end
      end
    end
  end

  assign iss_valid = iss_valid_q;
  assign iss_op    = iss_op_q;
  assign iss_rob   = iss_rob_q;
  assign iss_v1    = iss_v1_q;
  assign iss_v2    = iss_v2_q;
  assign iss_imm   = iss_imm_q;
  assign iss_pc    = iss_pc_q;

endmodule

// File: tb/tb_rs_age_station.sv
// Testbench for rs_age_station: directed scenarios plus randomized traffic,
// checked every cycle against an age-ordered queue model of the station.
module tb_rs_age_station;
  localparam int DEPTH  = 16;
  localparam int DATA_W = 32;
  localparam int ROB_W  = 4;
  localparam int OP_W   = 6;
  localparam int N_CDB  = 3;
  localparam int CNT_W  = $clog2(DEPTH+1);

  logic                    clk = 1'b0;
  logic                    rst, rdy, flush, in_valid;
  logic [OP_W-1:0]         in_op;
  logic [ROB_W-1:0]        in_rob, in_q1, in_q2;
  logic [DATA_W-1:0]       in_v1, in_v2, in_imm, in_pc;
  logic                    out_full;
  logic [CNT_W-1:0]        out_count;
  logic [N_CDB-1:0]        cdb_valid;
  logic [N_CDB*ROB_W-1:0]  cdb_tag;
  logic [N_CDB*DATA_W-1:0] cdb_data;
  logic                    iss_valid, iss_ready;
  logic [OP_W-1:0]         iss_op;
  logic [ROB_W-1:0]        iss_rob;
  logic [DATA_W-1:0]       iss_v1, iss_v2, iss_imm, iss_pc;

  always #5 clk = ~clk;

  rs_age_station #(
    .DEPTH(DEPTH), .DATA_W(DATA_W), .ROB_W(ROB_W), .OP_W(OP_W), .N_CDB(N_CDB)
  ) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
    .in_valid(in_valid), .in_op(in_op), .in_rob(in_rob),
    .in_v1(in_v1), .in_v2(in_v2), .in_q1(in_q1), .in_q2(in_q2),
    .in_imm(in_imm), .in_pc(in_pc),
    .out_full(out_full), .out_count(out_count),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .iss_valid(iss_valid), .iss_ready(iss_ready),
    .iss_op(iss_op), .iss_rob(iss_rob), .iss_v1(iss_v1), .iss_v2(iss_v2),
    .iss_imm(iss_imm), .iss_pc(iss_pc)
  );

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [OP_W-1:0]   op;
    logic [ROB_W-1:0]  rob, q1, q2;
    logic [DATA_W-1:0] v1, v2, imm, pc;
  } ent_t;

  ent_t mq[$];          // waiting instructions, oldest first
  logic m_iss_valid;
  ent_t m_iss;

  int checks = 0;
  int errors = 0;
  logic [ROB_W-1:0]  log_rob[$];
  logic [DATA_W-1:0] log_v1[$];
  logic [DATA_W-1:0] log_v2[$];

  // Apply this cycle's broadcasts to one instruction; first channel wins.
  function automatic ent_t wake_ent(ent_t e);
    ent_t r = e;
    for (int c = 0; c < N_CDB; c++) begin
      if (cdb_valid[c]) begin
        if (r.q1 != 0 && cdb_tag[c*ROB_W +: ROB_W] == r.q1) begin
          r.q1 = 0; r.v1 = cdb_data[c*DATA_W +: DATA_W];
        end
        if (r.q2 != 0 && cdb_tag[c*ROB_W +: ROB_W] == r.q2) begin
          r.q2 = 0; r.v2 = cdb_data[c*DATA_W +: DATA_W];
        end
      end
    end
    return r;
  endfunction

  task automatic model_step();
    int   pick;
    bit   full, load;
    ent_t ne;
    if (rst) begin
      mq.delete();
      m_iss_valid = 1'b0;
      m_iss = '{default: 0};
    end else if (rdy) begin
      if (flush) begin
        mq.delete();
        m_iss_valid = 1'b0;
      end else begin
        full = (mq.size() == DEPTH);
        load = !m_iss_valid || iss_ready;
        pick = -1;
        if (load) begin
          for (int k = 0; k < mq.size(); k++) begin
            if (mq[k].q1 == 0 && mq[k].q2 == 0) begin
              pick = k;
              break;
            end
          end
        end
        for (int k = 0; k < mq.size(); k++) mq[k] = wake_ent(mq[k]);
        if (load) begin
          if (pick >= 0) begin
            m_iss = mq[pick];
            m_iss_valid = 1'b1;
            mq.delete(pick);
          end else begin
            m_iss_valid = 1'b0;
          end
        end
        if (in_valid && !full) begin
          ne = '{op: in_op, rob: in_rob, q1: in_q1, q2: in_q2,
                 v1: in_v1, v2: in_v2, imm: in_imm, pc: in_pc};
          mq.push_back(wake_ent(ne));
        end
      end
    end
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare();
    chk("iss_valid", 64'(iss_valid), 64'(m_iss_valid));
    chk("out_count", 64'(out_count), 64'(mq.size()));
    chk("out_full", 64'(out_full), 64'(mq.size() == DEPTH));
    if (m_iss_valid) begin
      chk("iss_op",  64'(iss_op),  64'(m_iss.op));
      chk("iss_rob", 64'(iss_rob), 64'(m_iss.rob));
      chk("iss_v1",  64'(iss_v1),  64'(m_iss.v1));
      chk("iss_v2",  64'(iss_v2),  64'(m_iss.v2));
      chk("iss_imm", 64'(iss_imm), 64'(m_iss.imm));
      chk("iss_pc",  64'(iss_pc),  64'(m_iss.pc));
    end
  endtask

  // One clock: record a handshake about to complete, advance, compare.
  task automatic cycle();
    if (rst === 1'b0 && rdy === 1'b1 && flush === 1'b0 &&
        iss_valid === 1'b1 && iss_ready === 1'b1) begin
      log_rob.push_back(iss_rob);
      log_v1.push_back(iss_v1);
      log_v2.push_back(iss_v2);
      $display("issue rob=%0d op=%0d v1=%0h v2=%0h imm=%0h pc=%0h",
               iss_rob, iss_op, iss_v1, iss_v2, iss_imm, iss_pc);
    end
    @(posedge clk);
    model_step();
    #1;
    compare();
  endtask

  task automatic idle_inputs();
    rst = 0; rdy = 1; flush = 0; in_valid = 0;
    cdb_valid = '0; cdb_tag = '0; cdb_data = '0;
  endtask

  task automatic dispatch(input int op, input int rob, input int q1, input int v1,
                          input int q2, input int v2);
    in_valid = 1;
    in_op  = OP_W'(op);
    in_rob = ROB_W'(rob);
    in_q1  = ROB_W'(q1);
    in_v1  = DATA_W'(v1);
    in_q2  = ROB_W'(q2);
    in_v2  = DATA_W'(v2);
    in_imm = DATA_W'(rob * 16);
    in_pc  = DATA_W'(32'h1000 + rob * 4);
    cycle();
    in_valid = 0;
  endtask

  task automatic clear_log();
    log_rob.delete(); log_v1.delete(); log_v2.delete();
  endtask

  initial begin
    idle_inputs();
    iss_ready = 1;
    in_op = '0; in_rob = '0; in_q1 = '0; in_q2 = '0;
    in_v1 = '0; in_v2 = '0; in_imm = '0; in_pc = '0;

    // Reset
    rst = 1;
    cycle(); cycle();
    chk("rst_iss_valid", 64'(iss_valid), 0);
    chk("rst_iss_op", 64'(iss_op), 0);
    chk("rst_iss_rob", 64'(iss_rob), 0);
    chk("rst_iss_v1", 64'(iss_v1), 0);
    chk("rst_out_full", 64'(out_full), 0);
    chk("rst_out_count", 64'(out_count), 0);
    rst = 0;

    // Basic
    dispatch(3, 5, 0, 10, 0, 20);
    chk("basic_count_1", 64'(out_count), 1);
    chk("basic_not_yet", 64'(iss_valid), 0);
    cycle();
    chk("basic_valid", 64'(iss_valid), 1);
    chk("basic_rob", 64'(iss_rob), 5);
    chk("basic_v1", 64'(iss_v1), 10);
    chk("basic_v2", 64'(iss_v2), 20);
    chk("basic_count_0", 64'(out_count), 0);
    cycle();
    clear_log();

    // Age order
    dispatch(1, 1, 7, 0, 0, 11);
    dispatch(1, 2, 0, 12, 0, 13);
    dispatch(1, 3, 0, 14, 0, 15);
    cycle(); cycle();
    cdb_valid = 3'b100;
    cdb_tag[2*ROB_W +: ROB_W] = 4'd7;
    cdb_data[2*DATA_W +: DATA_W] = 32'h55;
    cycle();
    idle_inputs();
    for (int k = 0; k < 4; k++) cycle();
    chk("age_n", 64'(log_rob.size()), 3);
    if (log_rob.size() == 3) begin
      chk("age_first", 64'(log_rob[0]), 2);
      chk("age_second", 64'(log_rob[1]), 3);
      chk("age_third", 64'(log_rob[2]), 1);
      chk("age_a_v1", 64'(log_v1[2]), 64'h55);
    end

    // Dispatch bypass
    cdb_valid = 3'b001;
    cdb_tag[0 +: ROB_W] = 4'd9;
    cdb_data[0 +: DATA_W] = 32'hAB;
    dispatch(2, 6, 0, 1, 9, 32'hDEAD);
    idle_inputs();
    cycle();
    chk("byp_valid", 64'(iss_valid), 1);
    chk("byp_rob", 64'(iss_rob), 6);
    chk("byp_v2", 64'(iss_v2), 64'hAB);
    cycle();

    // Back-pressure
    iss_ready = 0;
    dispatch(4, 1, 0, 100, 0, 101);
    dispatch(4, 2, 0, 200, 0, 201);
    dispatch(4, 3, 0, 300, 0, 301);
    for (int k = 0; k < 5; k++) begin
      cycle();
      chk("bp_valid", 64'(iss_valid), 1);
      chk("bp_rob", 64'(iss_rob), 1);
      chk("bp_v1", 64'(iss_v1), 100);
    end
    clear_log();
    iss_ready = 1;
    for (int k = 0; k < 3; k++) cycle();
    chk("bp_burst_n", 64'(log_rob.size()), 3);
    if (log_rob.size() == 3) begin
      chk("bp_burst_0", 64'(log_rob[0]), 1);
      chk("bp_burst_1", 64'(log_rob[1]), 2);
      chk("bp_burst_2", 64'(log_rob[2]), 3);
    end
    cycle();

    // Full / flush
    for (int k = 0; k < DEPTH; k++) dispatch(5, k, 13, 0, 0, k);
    chk("full_flag", 64'(out_full), 1);
    chk("full_count", 64'(out_count), 16);
    dispatch(5, 15, 0, 1, 0, 2);
    chk("full_ignored", 64'(out_count), 16);
    flush = 1;
    dispatch(6, 7, 0, 3, 0, 4);
    flush = 0;
    chk("flush_count", 64'(out_count), 0);
    chk("flush_valid", 64'(iss_valid), 0);
    cycle(); cycle();
    chk("flush_nowrite", 64'(iss_valid), 0);
    chk("flush_count2", 64'(out_count), 0);

    // Freeze
    dispatch(7, 4, 6, 0, 0, 9);
    cycle();
    rdy = 0;
    cdb_valid = 3'b010;
    cdb_tag[ROB_W +: ROB_W] = 4'd6;
    cdb_data[DATA_W +: DATA_W] = 32'h77;
    cycle();
    idle_inputs();
    cycle(); cycle();
    chk("freeze_lost", 64'(iss_valid), 0);
    chk("freeze_count", 64'(out_count), 1);
    cdb_valid = 3'b010;
    cdb_tag[ROB_W +: ROB_W] = 4'd6;
    cdb_data[DATA_W +: DATA_W] = 32'h77;
    cycle();
    idle_inputs();
    iss_ready = 0;
    cycle();
    chk("wake_valid", 64'(iss_valid), 1);
    chk("wake_v1", 64'(iss_v1), 64'h77);
    cycle();
    rst = 1;
    cycle();
    rst = 0;
    chk("midrst_valid", 64'(iss_valid), 0);
    chk("midrst_rob", 64'(iss_rob), 0);
    chk("midrst_v1", 64'(iss_v1), 0);
    chk("midrst_pc", 64'(iss_pc), 0);
    chk("midrst_count", 64'(out_count), 0);
    iss_ready = 1;

    // Randomized traffic
    for (int n = 0; n < 1500; n++) begin
      rst      = ($urandom_range(0, 199) == 0);
      rdy      = ($urandom_range(0, 9) != 0);
      flush    = ($urandom_range(0, 59) == 0);
      in_valid = ($urandom_range(0, 9) < 7);
      in_op    = OP_W'($urandom);
      in_rob   = ROB_W'($urandom_range(1, 15));
      in_q1    = ($urandom_range(0, 1) == 0) ? '0 : ROB_W'($urandom_range(1, 7));
      in_q2    = ($urandom_range(0, 1) == 0) ? '0 : ROB_W'($urandom_range(1, 7));
      in_v1    = $urandom;
      in_v2    = $urandom;
      in_imm   = $urandom;
      in_pc    = $urandom;
      cdb_valid = N_CDB'($urandom);
      for (int c = 0; c < N_CDB; c++) begin
        cdb_tag[c*ROB_W +: ROB_W]    = ROB_W'($urandom_range(0, 7));
        cdb_data[c*DATA_W +: DATA_W] = $urandom;
      end
      iss_ready = ($urandom_range(0, 9) < 6);
      cycle();
    end

    idle_inputs();
    iss_ready = 1;
    for (int k = 0; k < 4; k++) cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
